// File: rtl/pio_bus_master.sv
// pio_bus_master: bus-to-PIO command sequencer.
// Turns single-beat requests into one-cycle PIO control strobes.
module pio_bus_master #(
  parameter int          TIMEOUT = 1024,
  parameter logic [31:0] VERSION = 32'h0001_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [7:0]  req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [5:0]  pio_action,
  output logic [4:0]  pio_index,
  output logic [1:0]  pio_mindex,
  output logic [31:0] pio_din,
  input  logic [31:0] pio_dout,
  input  logic [3:0]  pio_tx_full,
  input  logic [3:0]  pio_rx_empty
);

  localparam logic [5:0] A_NONE  = 6'd0;
  localparam logic [5:0] A_INSTR = 6'd1;
  localparam logic [5:0] A_PULL  = 6'd8;

  localparam logic [31:0] TMO = 32'(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_ISSUE,
    S_CAPTURE,
    S_RESP
  } state_t;

  state_t state_q, state_d;

  logic [7:0]  addr_q, addr_d;
  logic        wr_q, wr_d;
  logic [15:0] cnt_q, cnt_d;
  logic        err_q, err_d;
  logic [31:0] rdata_q, rdata_d;
  logic [4:0]  index_q, index_d;
  logic [1:0]  mindex_q, mindex_d;
  logic [31:0] din_q, din_d;

  logic [4:0] sel;
  logic       wr_ok, rd_ok;
  logic [5:0] wr_act, rd_act;
  logic       dec_err, dec_ver;
  logic [5:0] dec_act;
  logic       dec_push, dec_pull;
  logic       blocked, timed_out;
  logic       accept;

  assign sel    = addr_q[4:0];
  assign accept = (state_q == S_IDLE) && req_valid;

  // Decode the latched address into an action and direction check
  always_comb begin
    wr_ok   = 1'b0;
    rd_ok   = 1'b0;
    wr_act  = A_NONE;
    rd_act  = A_NONE;
    dec_ver = 1'b0;
    if (!addr_q[7]) begin
      wr_ok  = 1'b1;
      wr_act = A_INSTR;
    end else begin
      unique case (1'b1)
        (sel <= 5'd5): begin
          wr_ok  = 1'b1;
          wr_act = {1'b0, sel} + 6'd2;
        end
        (sel == 5'd6): begin
          rd_ok  = 1'b1;
          rd_act = A_PULL;
        end
        (sel >= 5'd8 && sel <= 5'd15): begin
          wr_ok  = 1'b1;
          wr_act = {1'b0, sel} + 6'd1;
        end
        (sel >= 5'd16 && sel <= 5'd23): begin
          rd_ok  = 1'b1;
          rd_act = {1'b0, sel} + 6'd1;
        end
        (sel == 5'd24): begin
          rd_ok   = 1'b1;
          dec_ver = 1'b1;
        end
        default: ;
      endcase
    end
    dec_err  = wr_q ? !wr_ok : !rd_ok;
    dec_act  = wr_q ? wr_act : rd_act;
    dec_push = wr_q && addr_q[7] && (sel == 5'd5);
    dec_pull = !wr_q && addr_q[7] && (sel == 5'd6);
  end

  // FIFO flag gating and wait-limit detection
  always_comb begin
    blocked = (dec_push && pio_tx_full[mindex_q]) ||
              (dec_pull && pio_rx_empty[mindex_q]);
    timed_out = (TMO != 32'd0) && ({16'd0, cnt_q} >= TMO);
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:
        if (req_valid) state_d = S_CHECK;
      S_CHECK:
        if (dec_err)        state_d = S_RESP;
        else if (!blocked)  state_d = S_ISSUE;
        else if (timed_out) state_d = S_RESP;
      S_ISSUE:
        state_d = wr_q ? S_RESP : S_CAPTURE;
      S_CAPTURE:
        state_d = S_RESP;
      S_RESP:
        state_d = S_IDLE;
      default:
        state_d = S_IDLE;
    endcase
  end

  // Outputs derived from state; reset masks strobes immediately
  always_comb begin
    req_ready  = (state_q == S_IDLE) && !reset;
    rsp_valid  = (state_q == S_RESP) && !reset;
    rsp_err    = rsp_valid && err_q;
    rsp_rdata  = rdata_q;
    pio_action = ((state_q == S_ISSUE) && !reset) ? dec_act : A_NONE;
    pio_index  = index_q;
    pio_mindex = mindex_q;
    pio_din    = din_q;
  end

  // Request latch, wait counter, error flag and read capture
  always_comb begin
    addr_d   = addr_q;
    wr_d     = wr_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    rdata_d  = rdata_q;
    index_d  = index_q;
    mindex_d = mindex_q;
    din_d    = din_q;
    if (accept) begin
      addr_d   = req_addr;
      wr_d     = req_write;
      cnt_d    = 16'd0;
      err_d    = 1'b0;
      rdata_d  = 32'd0;
      index_d  = req_addr[4:0];
      mindex_d = req_addr[7] ? req_addr[6:5] : 2'd0;
      din_d    = req_write ? req_wdata : 32'd0;
    end else if (state_q == S_CHECK) begin
      if (dec_err) begin
        err_d = 1'b1;
      end else if (blocked) begin
        if (timed_out)            err_d = 1'b1;
        else if (cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
      end
    end else if (state_q == S_CAPTURE) begin
      rdata_d = dec_ver ? VERSION : pio_dout;
    end
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q   <= 8'd0;
      wr_q     <= 1'b0;
      cnt_q    <= 16'd0;
      err_q    <= 1'b0;
      rdata_q  <= 32'd0;
      index_q  <= 5'd0;
      mindex_q <= 2'd0;
      din_q    <= 32'd0;
    end else begin
      addr_q   <= addr_d;
      wr_q     <= wr_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
      rdata_q  <= rdata_d;
      index_q  <= index_d;
      mindex_q <= mindex_d;
      din_q    <= din_d;
    end
  end

endmodule

// File: tb/tb_pio_bus_master.sv
// tb_pio_bus_master: directed and randomized checks
// against a transaction-level model of the sequencer.
module tb_pio_bus_master;

  localparam int TMO = 16;
  localparam logic [31:0] VER = 32'h0001_0000;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [7:0]  req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [5:0]  pio_action;
  logic [4:0]  pio_index;
  logic [1:0]  pio_mindex;
  logic [31:0] pio_din;
  logic [31:0] pio_dout;
  logic [3:0]  pio_tx_full;
  logic [3:0]  pio_rx_empty;

  int checks;
  int errors;

  pio_bus_master #(.TIMEOUT(TMO)) dut (
    .clk(clk),
    .reset(reset),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_write(req_write),
    .req_addr(req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err),
    .pio_action(pio_action),
    .pio_index(pio_index),
    .pio_mindex(pio_mindex),
    .pio_din(pio_din),
    .pio_dout(pio_dout),
    .pio_tx_full(pio_tx_full),
    .pio_rx_empty(pio_rx_empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Simple PIO model: stores written registers, returns
  // registered data for read actions.
  logic [31:0] pio_reg [64];
  logic [31:0] rx_word;

  always @(posedge clk) begin
    if (pio_action != 6'd0) begin
      if ((pio_action >= 6'd2 && pio_action <= 6'd7) ||
          (pio_action >= 6'd9 && pio_action <= 6'd16))
        pio_reg[pio_action] <= pio_din;
      case (pio_action)
        6'd8:    pio_dout <= rx_word;
        6'd19:   pio_dout <= pio_reg[12];
        6'd20:   pio_dout <= pio_reg[13];
        6'd22:   pio_dout <= pio_reg[14];
        6'd23:   pio_dout <= pio_reg[15];
        default: pio_dout <= 32'hC0DE_0000 | {26'd0, pio_action};
      endcase
    end
  end

  // Register map as tables: code per sel, -1 where absent
  int wr_code [32];
  int rd_code [32];
  logic [31:0] sh [32];

  typedef struct {
    int          rsp;
    int          stb;
    int          nstb;
    logic        err;
    logic [31:0] rd;
    logic [5:0]  act;
    logic [4:0]  idx;
    logic [1:0]  mi;
    logic [31:0] din;
  } obs_t;

  typedef struct {
    logic        err;
    logic [5:0]  act;
    int          issue;
    int          rsp;
    logic [31:0] rdata;
    logic [4:0]  idx;
    logic [1:0]  mi;
    logic [31:0] din;
  } exp_t;

  task automatic init_tables();
    for (int i = 0; i < 32; i++) begin
      wr_code[i] = -1;
      rd_code[i] = -1;
      sh[i] = 32'd0;
    end
    for (int i = 0; i < 64; i++) pio_reg[i] = 32'd0;
    wr_code[0] = 2;  wr_code[1] = 3;  wr_code[2] = 4;
    wr_code[3] = 5;  wr_code[4] = 6;  wr_code[5] = 7;
    rd_code[6] = 8;
    wr_code[8] = 9;   wr_code[9] = 10;  wr_code[10] = 11;
    wr_code[11] = 12; wr_code[12] = 13; wr_code[13] = 14;
    wr_code[14] = 15; wr_code[15] = 16;
    rd_code[16] = 17; rd_code[17] = 18; rd_code[18] = 19;
    rd_code[19] = 20; rd_code[20] = 21; rd_code[21] = 22;
    rd_code[22] = 23; rd_code[23] = 24;
  endtask

  // Transaction-level prediction; b = cycles the target flag blocks
  function automatic exp_t predict(input logic wr, input logic [7:0] a,
                                   input logic [31:0] wd, input int b);
    exp_t e;
    int s;
    logic ver;
    logic flagged;
    int w;
    s = int'(a[4:0]);
    ver = 1'b0;
    e.err = 1'b0;
    e.act = 6'd0;
    e.idx = a[4:0];
    e.mi = a[7] ? a[6:5] : 2'd0;
    e.din = wr ? wd : 32'd0;
    e.rdata = 32'd0;
    if (!a[7]) begin
      if (wr) e.act = 6'd1;
      else    e.err = 1'b1;
    end else if (wr) begin
      if (wr_code[s] < 0) e.err = 1'b1;
      else e.act = 6'(wr_code[s]);
    end else begin
      if (s == 24) ver = 1'b1;
      else if (rd_code[s] < 0) e.err = 1'b1;
      else e.act = 6'(rd_code[s]);
    end
    flagged = a[7] && ((wr && s == 5) || (!wr && s == 6));
    w = flagged ? b : 0;
    if (e.err) begin
      e.act = 6'd0;
      e.issue = -1;
      e.rsp = 2;
    end else if (w > TMO) begin
      e.err = 1'b1;
      e.act = 6'd0;
      e.issue = -1;
      e.rsp = TMO + 2;
    end else begin
      e.issue = w + 2;
      e.rsp = e.issue + (wr ? 1 : 2);
      if (!wr) begin
        if (ver)          e.rdata = VER;
        else if (s == 6)  e.rdata = rx_word;
        else if (s == 18) e.rdata = sh[11];
        else if (s == 19) e.rdata = sh[12];
        else if (s == 21) e.rdata = sh[13];
        else if (s == 22) e.rdata = sh[14];
        else e.rdata = 32'hC0DE_0000 | {26'd0, e.act};
      end
    end
    return e;
  endfunction

  // Drive one request and observe it cycle by cycle; flags are
  // cleared at the start of cycle rel (relative to accept edge 0).
  task automatic run(input logic wr, input logic [7:0] a,
                     input logic [31:0] wd, input logic [3:0] full,
                     input logic [3:0] empty, input int rel,
                     output obs_t o);
    int g;
    o.rsp = -1; o.stb = -1; o.nstb = 0; o.err = 1'b0;
    o.rd = 32'd0; o.act = 6'd0; o.idx = 5'd0;
    o.mi = 2'd0; o.din = 32'd0;
    @(negedge clk);
    pio_tx_full = full;
    pio_rx_empty = empty;
    req_valid = 1'b1;
    req_write = wr;
    req_addr = a;
    req_wdata = wd;
    g = 0;
    while (!req_ready && g < 50) begin
      @(negedge clk);
      g++;
    end
    @(posedge clk);
    #1 req_valid = 1'b0;
    for (int k = 1; k <= 100 && o.rsp < 0; k++) begin
      if (k == rel) begin
        pio_tx_full = 4'd0;
        pio_rx_empty = 4'd0;
      end
      @(negedge clk);
      if (pio_action != 6'd0) begin
        o.nstb++;
        o.stb = k;
        o.act = pio_action;
        o.idx = pio_index;
        o.mi = pio_mindex;
        o.din = pio_din;
      end
      if (rsp_valid) begin
        o.rsp = k;
        o.err = rsp_err;
        o.rd = rsp_rdata;
      end
      @(posedge clk);
      #1;
    end
    pio_tx_full = 4'd0;
    pio_rx_empty = 4'd0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr = 8'd0;
    req_wdata = 32'd0;
    pio_tx_full = 4'd0;
    pio_rx_empty = 4'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b0 || rsp_valid !== 1'b0 || pio_action !== 6'd0) begin
      errors++;
      $display("FAIL reset_hold ready=%b valid=%b act=%0d want 0 0 0", req_ready, rsp_valid, pio_action);
    end
    reset = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (req_ready !== 1'b1 || rsp_err !== 1'b0 || rsp_rdata !== 32'd0 ||
        pio_index !== 5'd0 || pio_mindex !== 2'd0 || pio_din !== 32'd0) begin
      errors++;
      $display("FAIL reset_release ready=%b err=%b rd=%h idx=%0d mi=%0d din=%h want 1 0 0 0 0 0", req_ready, rsp_err, rsp_rdata, pio_index, pio_mindex, pio_din);
    end
  endtask

  task automatic test_instr();
    obs_t o;
    run(1'b1, 8'h03, 32'h0000_E081, 4'd0, 4'd0, 1, o);
    checks++;
    if (o.nstb !== 1 || o.stb !== 2 || o.act !== 6'd1 || o.idx !== 5'd3 || o.din !== 32'h0000_E081) begin
      errors++;
      $display("FAIL instr_strobe n=%0d cyc=%0d act=%0d idx=%0d din=%h want 1 2 1 3 0000e081", o.nstb, o.stb, o.act, o.idx, o.din);
    end
    checks++;
    if (o.rsp !== 3 || o.err !== 1'b0 || o.rd !== 32'd0) begin
      errors++;
      $display("FAIL instr_rsp cyc=%0d err=%b rd=%h want 3 0 0", o.rsp, o.err, o.rd);
    end
  endtask

  task automatic test_irq_readback();
    obs_t o;
    run(1'b1, 8'h8B, 32'h0000_0ABC, 4'd0, 4'd0, 1, o);
    sh[11] = 32'h0000_0ABC;
    checks++;
    if (o.rsp !== 3 || o.err !== 1'b0 || o.act !== 6'd12 || o.din !== 32'h0000_0ABC) begin
      errors++;
      $display("FAIL irq_wr cyc=%0d err=%b act=%0d din=%h want 3 0 12 00000abc", o.rsp, o.err, o.act, o.din);
    end
    run(1'b0, 8'h92, 32'hFFFF_FFFF, 4'd0, 4'd0, 1, o);
    checks++;
    if (o.rsp !== 4 || o.err !== 1'b0 || o.rd !== 32'h0000_0ABC || o.act !== 6'd19 || o.din !== 32'd0) begin
      errors++;
      $display("FAIL irq_rd cyc=%0d err=%b rd=%h act=%0d din=%h want 4 0 00000abc 19 0", o.rsp, o.err, o.rd, o.act, o.din);
    end
  endtask

  task automatic test_tx_full();
    obs_t o;
    run(1'b1, 8'hC5, 32'h1111_2222, 4'b0100, 4'd0, 1000, o);
    checks++;
    if (o.nstb !== 0 || o.rsp !== TMO + 2 || o.err !== 1'b1 || o.rd !== 32'd0) begin
      errors++;
      $display("FAIL tx_timeout n=%0d cyc=%0d err=%b rd=%h want 0 %0d 1 0", o.nstb, o.rsp, o.err, o.rd, TMO + 2);
    end
    run(1'b1, 8'hC5, 32'h3333_4444, 4'b0100, 4'd0, 6, o);
    checks++;
    if (o.nstb !== 1 || o.stb !== 7 || o.act !== 6'd7 || o.mi !== 2'd2 || o.rsp !== 8 || o.err !== 1'b0) begin
      errors++;
      $display("FAIL tx_release n=%0d stb=%0d act=%0d mi=%0d rsp=%0d err=%b want 1 7 7 2 8 0", o.nstb, o.stb, o.act, o.mi, o.rsp, o.err);
    end
    run(1'b1, 8'hC5, 32'h5555_6666, 4'b0100, 4'd0, TMO + 1, o);
    checks++;
    if (o.nstb !== 1 || o.stb !== TMO + 2 || o.rsp !== TMO + 3 || o.err !== 1'b0) begin
      errors++;
      $display("FAIL tx_edge_ok n=%0d stb=%0d rsp=%0d err=%b want 1 %0d %0d 0", o.nstb, o.stb, o.rsp, o.err, TMO + 2, TMO + 3);
    end
    run(1'b1, 8'hC5, 32'h7777_8888, 4'b0100, 4'd0, TMO + 2, o);
    checks++;
    if (o.nstb !== 0 || o.rsp !== TMO + 2 || o.err !== 1'b1) begin
      errors++;
      $display("FAIL tx_edge_to n=%0d rsp=%0d err=%b want 0 %0d 1", o.nstb, o.rsp, o.err, TMO + 2);
    end
  endtask

  task automatic test_rx_empty();
    obs_t o;
    rx_word = 32'h1234_5678;
    run(1'b0, 8'hA6, 32'hDEAD_BEEF, 4'd0, 4'b0010, 9, o);
    checks++;
    if (o.nstb !== 1 || o.stb !== 10 || o.act !== 6'd8 || o.mi !== 2'd1 || o.din !== 32'd0) begin
      errors++;
      $display("FAIL rx_pull n=%0d stb=%0d act=%0d mi=%0d din=%h want 1 10 8 1 0", o.nstb, o.stb, o.act, o.mi, o.din);
    end
    checks++;
    if (o.rsp !== 12 || o.err !== 1'b0 || o.rd !== 32'h1234_5678) begin
      errors++;
      $display("FAIL rx_rsp cyc=%0d err=%b rd=%h want 12 0 12345678", o.rsp, o.err, o.rd);
    end
  endtask

  task automatic test_errors();
    obs_t o;
    logic wr_t [4];
    logic [7:0] a_t [4];
    wr_t[0] = 1'b1; a_t[0] = 8'h86;
    wr_t[1] = 1'b0; a_t[1] = 8'h05;
    wr_t[2] = 1'b1; a_t[2] = 8'h9E;
    wr_t[3] = 1'b0; a_t[3] = 8'hFE;
    for (int i = 0; i < 4; i++) begin
      run(wr_t[i], a_t[i], 32'hCAFE_F00D, 4'd0, 4'd0, 1, o);
      checks++;
      if (o.nstb !== 0 || o.rsp !== 2 || o.err !== 1'b1 || o.rd !== 32'd0) begin
        errors++;
        $display("FAIL err_%0d n=%0d rsp=%0d err=%b rd=%h want 0 2 1 0", i, o.nstb, o.rsp, o.err, o.rd);
      end
    end
    run(1'b0, 8'h98, 32'd0, 4'd0, 4'd0, 1, o);
    checks++;
    if (o.nstb !== 0 || o.rsp !== 4 || o.err !== 1'b0 || o.rd !== VER) begin
      errors++;
      $display("FAIL version n=%0d rsp=%0d err=%b rd=%h want 0 4 0 %h", o.nstb, o.rsp, o.err, o.rd, VER);
    end
  endtask

  task automatic test_reset_mid_wait();
    obs_t o;
    int nv;
    int na;
    @(negedge clk);
    pio_tx_full = 4'b0100;
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr = 8'hC5;
    req_wdata = 32'hAAAA_5555;
    @(posedge clk);
    #1 req_valid = 1'b0;
    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b0 || rsp_valid !== 1'b0 || pio_action !== 6'd0 ||
        pio_index !== 5'd0 || pio_mindex !== 2'd0 || pio_din !== 32'd0 || rsp_rdata !== 32'd0) begin
      errors++;
      $display("FAIL rst_wait_vals ready=%b valid=%b act=%0d idx=%0d mi=%0d din=%h rd=%h want all 0", req_ready, rsp_valid, pio_action, pio_index, pio_mindex, pio_din, rsp_rdata);
    end
    reset = 1'b0;
    nv = 0;
    na = 0;
    for (int k = 0; k < 25; k++) begin
      @(negedge clk);
      if (rsp_valid) nv++;
      if (pio_action != 6'd0) na++;
    end
    checks++;
    if (nv !== 0 || na !== 0) begin
      errors++;
      $display("FAIL rst_wait_quiet rsp=%0d act=%0d want 0 0", nv, na);
    end
    pio_tx_full = 4'd0;
    run(1'b1, 8'hC5, 32'h0BAD_CAFE, 4'd0, 4'd0, 1, o);
    checks++;
    if (o.nstb !== 1 || o.act !== 6'd7 || o.din !== 32'h0BAD_CAFE || o.rsp !== 3 || o.err !== 1'b0) begin
      errors++;
      $display("FAIL rst_wait_next n=%0d act=%0d din=%h rsp=%0d err=%b want 1 7 0badcafe 3 0", o.nstb, o.act, o.din, o.rsp, o.err);
    end
  endtask

  task automatic test_back_to_back();
    int rv [9];
    int rr [9];
    @(negedge clk);
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr = 8'h03;
    req_wdata = 32'h0000_0042;
    @(posedge clk);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      rv[k] = int'(rsp_valid);
      rr[k] = int'(req_ready);
      if (k == 8) req_valid = 1'b0;
      @(posedge clk);
    end
    #1;
    checks++;
    if (rv[3] !== 1 || rr[3] !== 0 || rr[4] !== 1 || rv[4] !== 0) begin
      errors++;
      $display("FAIL b2b_first rsp3=%0d rdy3=%0d rdy4=%0d rsp4=%0d want 1 0 1 0", rv[3], rr[3], rr[4], rv[4]);
    end
    checks++;
    if (rv[7] !== 1 || rr[5] !== 0 || rr[8] !== 1 || rv[6] !== 0) begin
      errors++;
      $display("FAIL b2b_second rsp7=%0d rdy5=%0d rdy8=%0d rsp6=%0d want 1 0 1 0", rv[7], rr[5], rr[8], rv[6]);
    end
    repeat (2) @(posedge clk);
  endtask

  task automatic test_random();
    obs_t o;
    exp_t e;
    logic wr;
    logic [7:0] a;
    logic [31:0] wd;
    logic [1:0] m;
    logic [3:0] full;
    logic [3:0] empty;
    int b;
    int kind;
    int bad;
    for (int n = 0; n < 60; n++) begin
      kind = $urandom_range(0, 3);
      m = 2'($urandom_range(0, 3));
      wd = $urandom;
      rx_word = $urandom;
      wr = 1'($urandom_range(0, 1));
      a = 8'($urandom);
      if (kind == 1) begin
        wr = 1'b1;
        a = {1'b1, m, 5'd5};
      end else if (kind == 2) begin
        wr = 1'b0;
        a = {1'b1, m, 5'd6};
      end else if (kind == 3) begin
        a = {1'b1, m, 5'($urandom_range(8, 24))};
      end
      b = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(0, TMO + 4);
      full = 4'($urandom);
      empty = 4'($urandom);
      full[a[6:5]] = (b > 0) && wr;
      empty[a[6:5]] = (b > 0) && !wr;
      e = predict(wr, a, wd, b);
      run(wr, a, wd, full, empty, b + 1, o);
      if (!e.err && wr && a[7] && a[4:0] >= 5'd11 && a[4:0] <= 5'd14)
        sh[a[4:0]] = wd;
      checks++;
      if (o.rsp !== e.rsp || o.err !== e.err || o.rd !== e.rdata) begin
        errors++;
        $display("FAIL rnd_rsp n=%0d wr=%b a=%h rsp=%0d err=%b rd=%h want %0d %b %h", n, wr, a, o.rsp, o.err, o.rd, e.rsp, e.err, e.rdata);
      end
      bad = 0;
      if (e.act == 6'd0) begin
        if (o.nstb != 0) bad = 1;
      end else if (o.nstb != 1 || o.stb != e.issue || o.act !== e.act ||
                   o.idx !== e.idx || o.mi !== e.mi || o.din !== e.din) begin
        bad = 1;
      end
      checks++;
      if (bad != 0) begin
        errors++;
        $display("FAIL rnd_stb n=%0d a=%h n=%0d cyc=%0d act=%0d idx=%0d mi=%0d din=%h want cyc %0d act %0d idx %0d mi %0d din %h", n, a, o.nstb, o.stb, o.act, o.idx, o.mi, o.din, e.issue, e.act, e.idx, e.mi, e.din);
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    pio_dout = 32'd0;
    rx_word = 32'd0;
    init_tables();
    test_reset();
    test_instr();
    test_irq_readback();
    test_tx_full();
    test_rx_empty();
    test_errors();
    test_reset_mid_wait();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
